// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and limits for the register access arbiter
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int RD_LAT_MAX  = 3;
    localparam int NUM_REQ_MAX = 8;
    localparam int WAIT_CNT_W  = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/reg_access_arbiter_if.sv
// rtl/reg_access_arbiter_if.sv - requester and register-bank signals of the arbiter
interface reg_access_arbiter_if #(
    parameter int DWIDTH  = 32,
    parameter int ALINES  = 7,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ALINES-1:0] req_addr;
    logic [NUM_REQ*DWIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DWIDTH-1:0]         req_rdata;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                      busy;
    logic                      bank_wr;
    logic [ALINES-1:0]         bank_addr;
    logic [DWIDTH-1:0]         bank_wdata;
    logic [DWIDTH-1:0]         bank_rdata;

    // Environment side: requesters plus the register bank's read port
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, bank_rdata,
        input  req_ack, req_rdata, grant_id, busy, bank_wr, bank_addr, bank_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, bank_rdata,
        output req_ack, req_rdata, grant_id, busy, bank_wr, bank_addr, bank_wdata
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last grant
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
    output logic                       o_any,
    output logic [$clog2(NUM_REQ)-1:0] o_winner
);
    localparam int GW = $clog2(NUM_REQ);

    int w_idx;

    // Scan farthest-first so the nearest set index after last_grant is written last
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = int'(i_last_grant) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_req[GW'(w_idx)]) begin
                o_any    = 1'b1;
                o_winner = GW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - round-robin sharing of the register-bank port among requesters
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int ALINES  = 7,
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    reg_access_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = WAIT_CNT_W;
    localparam logic [CW-1:0] LAT_LOAD = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    arb_state_t          r_state, w_state;
    logic                r_wr, w_wr;
    logic [CW-1:0]       r_wait_cnt, w_wait_cnt;
    logic [GW-1:0]       r_last_grant, w_last_grant;
    logic [GW-1:0]       r_grant_id, w_grant_id;
    logic [NUM_REQ-1:0]  r_req_ack, w_req_ack;
    logic [DWIDTH-1:0]   r_req_rdata, w_req_rdata;
    logic                r_busy, w_busy;
    logic                r_bank_wr, w_bank_wr;
    logic [ALINES-1:0]   r_bank_addr, w_bank_addr;
    logic [DWIDTH-1:0]   r_bank_wdata, w_bank_wdata;
    logic                w_any;
    logic [GW-1:0]       w_winner;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    // bank_addr/bank_wdata double as the latched request, so they hold between grants
    always_comb begin
        w_state      = r_state;
        w_wr         = r_wr;
        w_wait_cnt   = r_wait_cnt;
        w_last_grant = r_last_grant;
        w_grant_id   = r_grant_id;
        w_req_ack    = '0;
        w_req_rdata  = r_req_rdata;
        w_bank_wr    = 1'b0;
        w_bank_addr  = r_bank_addr;
        w_bank_wdata = r_bank_wdata;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_id   = w_winner;
                    w_wr         = bus.req_wr[w_winner];
                    w_bank_wr    = bus.req_wr[w_winner];
                    w_bank_addr  = bus.req_addr[int'(w_winner)*ALINES +: ALINES];
                    w_bank_wdata = bus.req_wdata[int'(w_winner)*DWIDTH +: DWIDTH];
                    w_state      = ACCESS;
                end
            end
            ACCESS: begin
                if (r_wr) begin
                    w_state = DONE;
                end else if (RD_LAT == 0) begin
                    w_req_rdata = bus.bank_rdata;
                    w_state     = DONE;
                end else begin
                    w_wait_cnt = LAT_LOAD;
                    w_state    = WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_req_rdata = bus.bank_rdata;
                    w_state     = DONE;
                end else begin
                    w_wait_cnt = r_wait_cnt - CW'(1);
                end
            end
            DONE: begin
                w_last_grant = r_grant_id;
                w_state      = IDLE;
            end
            default: w_state = IDLE;
        endcase
        if (w_state == DONE) begin
            w_req_ack[r_grant_id] = 1'b1;
        end
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_wr         <= 1'b0;
            r_wait_cnt   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_req_ack    <= '0;
            r_req_rdata  <= '0;
            r_busy       <= 1'b0;
            r_bank_wr    <= 1'b0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
        end else begin
            r_state      <= w_state;
            r_wr         <= w_wr;
            r_wait_cnt   <= w_wait_cnt;
            r_last_grant <= w_last_grant;
            r_grant_id   <= w_grant_id;
            r_req_ack    <= w_req_ack;
            r_req_rdata  <= w_req_rdata;
            r_busy       <= w_busy;
            r_bank_wr    <= w_bank_wr;
            r_bank_addr  <= w_bank_addr;
            r_bank_wdata <= w_bank_wdata;
        end
    end

    assign bus.req_ack    = r_req_ack;
    assign bus.req_rdata  = r_req_rdata;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = r_busy;
    assign bus.bank_wr    = r_bank_wr;
    assign bus.bank_addr  = r_bank_addr;
    assign bus.bank_wdata = r_bank_wdata;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb/tb_reg_access_arbiter.sv - self-checking bench for reg_access_arbiter
module tb_reg_access_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 7;
    localparam int NR  = 2;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_access_arbiter_if #(.DWIDTH(DW), .ALINES(AW), .NUM_REQ(NR)) bus  ();
    reg_access_arbiter_if #(.DWIDTH(DW), .ALINES(AW), .NUM_REQ(NR)) bus0 ();

    reg_access_arbiter #(.DWIDTH(DW), .ALINES(AW), .NUM_REQ(NR), .RD_LAT(LAT)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    reg_access_arbiter #(.DWIDTH(DW), .ALINES(AW), .NUM_REQ(NR), .RD_LAT(0)) u_dut0 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus0.slave)
    );

    // Register bank with a LAT-cycle read pipeline on the address
    logic [DW-1:0] mem [0:127];
    logic [AW-1:0] a_d1, a_d2;
    always @(posedge clk) begin
        if (bus.bank_wr) mem[bus.bank_addr] <= bus.bank_wdata;
        a_d1 <= bus.bank_addr;
        a_d2 <= a_d1;
    end
    assign bus.bank_rdata = mem[a_d2];

    logic [DW-1:0] mem0 [0:127];
    always @(posedge clk) begin
        if (bus0.bank_wr) mem0[bus0.bank_addr] <= bus0.bank_wdata;
    end
    assign bus0.bank_rdata = mem0[bus0.bank_addr];

    typedef struct {
        int            idx;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs [6];

    int got [$];
    int tms [$];

    logic          pend  [NR];
    logic          pwr   [NR];
    logic [AW-1:0] paddr [NR];
    logic [DW-1:0] pdata [NR];
    logic [DW-1:0] rmem   [16];
    logic          rknown [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_wr[i]             = wr;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},        64'(bus.req_ack), 64'(0));
        check({tag, "_rdata"},      64'(bus.req_rdata), 64'(0));
        check({tag, "_grant_id"},   64'(bus.grant_id), 64'(0));
        check({tag, "_busy"},       64'(bus.busy), 64'(0));
        check({tag, "_bank_wr"},    64'(bus.bank_wr), 64'(0));
        check({tag, "_bank_addr"},  64'(bus.bank_addr), 64'(0));
        check({tag, "_bank_wdata"}, 64'(bus.bank_wdata), 64'(0));
    endtask

    task automatic do_txn(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rdata);
        int n;
        int wr_seen;
        logic [NR-1:0] ack;
        set_req(i, 1'b1, wr, a, d);
        n = 0;
        wr_seen = 0;
        ack = '0;
        while (ack == '0 && n < 20) begin
            cyc();
            n++;
            if (bus.bank_wr) begin
                wr_seen++;
                check("bank_addr", 64'(bus.bank_addr), 64'(a));
                check("bank_wdata", 64'(bus.bank_wdata), 64'(d));
            end
            ack = bus.req_ack;
        end
        check("ack_vec", 64'(ack), 64'(1 << i));
        check("ack_latency", 64'(n), 64'(wr ? 2 : 2 + LAT));
        check("bank_wr_count", 64'(wr_seen), 64'(wr ? 1 : 0));
        check("grant_id", 64'(bus.grant_id), 64'(i));
        if (!wr) check("req_rdata", 64'(bus.req_rdata), 64'(exp_rdata));
        bus.req_valid[i] = 1'b0;
        cyc();
        check("no_double_ack", 64'(bus.req_ack), 64'(0));
        check("busy_after", 64'(bus.busy), 64'(0));
    endtask

    task automatic wait_ack(output logic [NR-1:0] ack);
        int n;
        n = 0;
        ack = '0;
        while (ack == '0 && n < 20) begin
            cyc();
            n++;
            ack = bus.req_ack;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] ack;
        int n;
        int ack0, ack0_at, ack1;
        int mlast, free_at, exp_at, exp_idx, w, lat;
        logic exp_rd, exp_chk;
        logic [DW-1:0] exp_data;

        vecs[0] = '{1, 1'b1, 7'h05, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b1, 7'h7F, 32'h12345678, 32'h0};
        vecs[2] = '{0, 1'b0, 7'h7F, 32'h0,        32'h12345678};
        vecs[3] = '{1, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{1, 1'b1, 7'h00, 32'hCAFEF00D, 32'h0};
        vecs[5] = '{0, 1'b0, 7'h00, 32'h0,        32'hCAFEF00D};

        bus.req_valid  = '0;
        bus.req_wr     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus0.req_valid = '0;
        bus0.req_wr    = '0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;

        cyc();
        cyc();
        check_all_zero("reset");
        check("reset_ack0", 64'(bus0.req_ack), 64'(0));
        rst_n = 1'b1;
        cyc();

        // RD_LAT=0 instance: write then read back, both acked at T+2
        for (int k = 0; k < 2; k++) begin
            bus0.req_valid[0]    = 1'b1;
            bus0.req_wr[0]       = (k == 0);
            bus0.req_addr[AW-1:0] = 7'h03;
            bus0.req_wdata[DW-1:0] = 32'hA5A5C3C3;
            n = 0;
            while (bus0.req_ack == '0 && n < 20) begin
                cyc();
                n++;
            end
            check("lat0_ack", 64'(bus0.req_ack), 64'(1));
            check("lat0_latency", 64'(n), 64'(2));
            if (k == 1) check("lat0_rdata", 64'(bus0.req_rdata), 64'(32'hA5A5C3C3));
            bus0.req_valid[0] = 1'b0;
            cyc();
        end

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
        end

        // Contention straight after reset: strict 0,1,0,1 rotation, 3 cycles apart
        apply_reset();
        set_req(0, 1'b1, 1'b1, 7'h10, 32'h00001000);
        set_req(1, 1'b1, 1'b1, 7'h11, 32'h00001100);
        n = 0;
        while (got.size() < 4 && n < 40) begin
            cyc();
            n++;
            if (bus.req_ack != '0) begin
                check("cont_onehot", 64'($onehot(bus.req_ack)), 64'(1));
                got.push_back(bus.req_ack[1] ? 1 : 0);
                tms.push_back(n);
            end
        end
        bus.req_valid = '0;
        check("cont_count", 64'(got.size()), 64'(4));
        for (int k = 0; k < got.size(); k++) check("cont_order", 64'(got[k]), 64'(k % 2));
        for (int k = 1; k < tms.size(); k++) check("cont_spacing", 64'(tms[k] - tms[k-1]), 64'(3));
        cyc();

        // Withdrawal: requester 1 pulses valid during requester 0's WAIT
        set_req(1, 1'b0, 1'b1, 7'h22, 32'h0BADF00D);
        set_req(0, 1'b1, 1'b0, 7'h7F, 32'h0);
        ack0 = 0; ack0_at = 0; ack1 = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 2) bus.req_valid[1] = 1'b1;
            if (c == 3) bus.req_valid[1] = 1'b0;
            if (bus.req_ack[0]) begin
                ack0++;
                ack0_at = c;
                bus.req_valid[0] = 1'b0;
                check("wd_rdata", 64'(bus.req_rdata), 64'(32'h12345678));
            end
            if (bus.req_ack[1]) ack1++;
        end
        check("wd_ack0_count", 64'(ack0), 64'(1));
        check("wd_ack0_at", 64'(ack0_at), 64'(2 + LAT));
        check("wd_ack1_count", 64'(ack1), 64'(0));
        check("wd_busy", 64'(bus.busy), 64'(0));
        // Last grant was 0, so with both requesting 1 must win first
        set_req(0, 1'b1, 1'b0, 7'h05, 32'h0);
        set_req(1, 1'b1, 1'b0, 7'h7F, 32'h0);
        wait_ack(ack);
        check("rr_after_wd_first", 64'(ack), 64'(2'b10));
        bus.req_valid[1] = 1'b0;
        wait_ack(ack);
        check("rr_after_wd_second", 64'(ack), 64'(2'b01));
        bus.req_valid[0] = 1'b0;
        cyc();

        // Reset during WAIT of a read
        set_req(0, 1'b1, 1'b0, 7'h7F, 32'h0);
        cyc();
        cyc();
        check("pre_reset_busy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.req_valid = '0;
        cyc();
        rst_n = 1'b1;
        ack1 = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (bus.req_ack != '0) ack1++;
        end
        check("midreset_no_ack", 64'(ack1), 64'(0));
        do_txn(1, 1'b0, 7'h05, 32'h0, 32'hDEADBEEF);

        // Randomized traffic against a transaction-level scheduling model
        apply_reset();
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int a = 0; a < 16; a++) rknown[a] = 1'b0;
        mlast = NR - 1;
        free_at = 0;
        exp_at = -1;
        exp_idx = 0;
        exp_rd = 1'b0;
        exp_chk = 1'b0;
        exp_data = '0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (c == exp_at) begin
                check("rand_ack", 64'(bus.req_ack), 64'(1 << exp_idx));
                if (exp_rd && exp_chk) check("rand_rdata", 64'(bus.req_rdata), 64'(exp_data));
                pend[exp_idx] = 1'b0;
                mlast = exp_idx;
            end else begin
                check("rand_noack", 64'(bus.req_ack), 64'(0));
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && c < 300 && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pwr[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = AW'($urandom_range(0, 15));
                    pdata[i] = $urandom;
                end
            end
            if (c >= free_at) begin
                w = -1;
                for (int k = NR; k >= 1; k--) begin
                    if (pend[(mlast + k) % NR]) w = (mlast + k) % NR;
                end
                if (w >= 0) begin
                    lat = pwr[w] ? 2 : 2 + LAT;
                    exp_at = c + lat;
                    free_at = exp_at + 1;
                    exp_idx = w;
                    exp_rd = !pwr[w];
                    if (pwr[w]) begin
                        rmem[paddr[w][3:0]]   = pdata[w];
                        rknown[paddr[w][3:0]] = 1'b1;
                    end else begin
                        exp_data = rmem[paddr[w][3:0]];
                        exp_chk  = rknown[paddr[w][3:0]];
                    end
                end
            end
            for (int i = 0; i < NR; i++) set_req(i, pend[i], pwr[i], paddr[i], pdata[i]);
        end
        n = 0;
        for (int i = 0; i < NR; i++) if (pend[i]) n++;
        check("rand_drained", 64'(n), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
